// File: rtl/ram_master_if.sv
// ram_master_if
//   Bundles the command port, the result port and the RAM pin group used by
//   ram_master. Only clk/reset stay outside the interface.
//
//   Command : cmd_valid, cmd_ready, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_data
//   Result  : rd_data, rd_valid, done, busy
//   RAM pins: mem_addr, mem_wdata, mem_we, mem_cs (to RAM), mem_rdata (from RAM)
//
//   modport slave  : the ram_master itself (takes commands, drives the RAM)
//   modport master : the commanding side, which also returns the RAM read data
interface ram_master_if #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int LW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic          mem_cs;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_data, mem_rdata,
    output cmd_ready, rd_data, rd_valid, done, busy,
           mem_addr, mem_wdata, mem_we, mem_cs
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_data, mem_rdata,
    input  cmd_ready, rd_data, rd_valid, done, busy,
           mem_addr, mem_wdata, mem_we, mem_cs
  );
endinterface

// File: rtl/ram_master.sv
// ram_master
//   Initiator for a 2^AW x DW single-port RAM (async read while CS, write on
//   posedge when CS && WE). Accepts read / write / fill / copy commands on a
//   valid/ready port and sequences the RAM address, data, WE and CS pins.
//
//   clk   : clock, all state changes on posedge
//   reset : synchronous, active-high
//   bus   : ram_master_if.slave (command port, result port, RAM pins)
//
//   All outputs are decoded from the state and registers only.
module ram_master #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int LW = 5
) (
  input  logic           clk,
  input  logic           reset,
  ram_master_if.slave    bus
);

  localparam int DEPTH = 1 << AW;
  // Counter must hold the full depth (e.g. 16 for AW=4), hence one extra bit.
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, FILL, CP_RD, CP_WR, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [AW-1:0] dst;
  logic [CW-1:0] cnt;
  logic [DW-1:0] data;
  logic [DW-1:0] cpbuf;
  logic [DW-1:0] rd_data_q;
  logic          is_read;
  logic          accept;
  logic [CW-1:0] eff_len;

  assign accept = (state == IDLE) && bus.cmd_valid;

  // Lengths beyond the RAM depth saturate to one full pass.
  always_comb begin
    eff_len = (int'(bus.cmd_len) > DEPTH) ? CW'(DEPTH) : CW'(bus.cmd_len);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            2'b00:   state_nxt = READ;
            2'b01:   state_nxt = WRITE;
            2'b10:   state_nxt = (eff_len == '0) ? DONE : FILL;
            default: state_nxt = (eff_len == '0) ? DONE : CP_RD;
          endcase
        end
      end
      READ:    state_nxt = DONE;
      WRITE:   state_nxt = DONE;
      FILL:    state_nxt = (cnt == CW'(1)) ? DONE : FILL;
      CP_RD:   state_nxt = CP_WR;
      CP_WR:   state_nxt = (cnt == CW'(1)) ? DONE : CP_RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, pointers, counter and captured read data. Pointers are
  // AW bits wide so the increment wraps at the top of the RAM for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      dst       <= '0;
      cnt       <= '0;
      data      <= '0;
      cpbuf     <= '0;
      rd_data_q <= '0;
      is_read   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr     <= bus.cmd_addr;
            dst     <= bus.cmd_dst;
            cnt     <= eff_len;
            data    <= bus.cmd_data;
            is_read <= (bus.cmd_op == 2'b00);
          end
        end
        READ:  rd_data_q <= bus.mem_rdata;
        FILL: begin
          ptr <= ptr + AW'(1);
          cnt <= cnt - CW'(1);
        end
        CP_RD: cpbuf <= bus.mem_rdata;
        CP_WR: begin
          ptr <= ptr + AW'(1);
          dst <= dst + AW'(1);
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Output decode; mem_* stay at 0 outside the RAM access states.
  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rd_data   = rd_data_q;
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      READ: begin
        bus.mem_cs   = 1'b1;
        bus.mem_addr = ptr;
      end
      WRITE, FILL: begin
        bus.mem_cs    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = ptr;
        bus.mem_wdata = data;
      end
      CP_RD: begin
        bus.mem_cs   = 1'b1;
        bus.mem_addr = ptr;
      end
      CP_WR: begin
        bus.mem_cs    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = dst;
        bus.mem_wdata = cpbuf;
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.rd_valid = is_read;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Initiator for the 16x8 single-port RAM (async read when CS, write on posedge clk when WE&&CS): accepts commands on a valid/ready port and sequences the RAM's address, data, WE and CS pins.
- Supports four operations: single read, single write, block fill, block copy.
- Sits between the CPU/test logic and the RAM instance. Is the only driver of the RAM's CS/WE.

Parameters:
- AW, 4, address width (RAM depth 2^AW).
- DW, 8, data width.
- LW, 5, length field width (0..2^AW meaningful).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master can accept; high only in IDLE.
- cmd_op  in  2  00 read, 01 write, 10 fill, 11 copy.
- cmd_addr  in  AW  read/write/fill start address; copy source.
- cmd_dst  in  AW  copy destination (ignored otherwise).
- cmd_len  in  LW  fill/copy word count (ignored for read/write).
- cmd_data  in  DW  write/fill data.
- rd_data  out  DW  read result, held until the next read completes.
- rd_valid  out  1  one-cycle pulse, read result valid.
- done  out  1  one-cycle pulse, any command complete.
- busy  out  1  high whenever not in IDLE.
- mem_addr  out  AW  to RAM Address.
- mem_wdata  out  DW  to RAM in.
- mem_rdata  in  DW  from RAM out.
- mem_we  out  1  to RAM WE.
- mem_cs  out  1  to RAM CS.

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-high.
- Reset (any state, including mid-command): next state IDLE. Counters, pointers and rd_data are set to 0. Outputs: cmd_ready=1, rd_valid=0, done=0, busy=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0. An aborted fill/copy leaves already-written words in place.
- Handshake: a command is accepted at the posedge where cmd_valid&&cmd_ready. All cmd_* fields are latched at that edge and may change afterwards.
- States: IDLE, READ, WRITE, FILL, CP_RD, CP_WR, DONE. All outputs are decoded from the state and registers only; no input-to-output combinational path.
- In IDLE and DONE, the mem_* outputs are all 0.
- IDLE: cmd_ready=1. On accept, go by cmd_op to READ, WRITE, FILL or CP_RD.
  - If fill/copy has effective length 0, go directly to DONE.
  - Effective length = min(cmd_len, 2^AW).
- READ (1 cycle): mem_cs=1, mem_we=0, mem_addr=addr. At the end edge, rd_data<=mem_rdata; go to DONE.
- WRITE (1 cycle): mem_cs=1, mem_we=1, mem_addr=addr, mem_wdata=data; go to DONE.
- FILL (len cycles): mem_cs=1, mem_we=1, mem_addr=ptr, mem_wdata=data.
  - Each edge: ptr<=ptr+1 mod 2^AW, cnt<=cnt-1.
  - When cnt==1 at an edge, go to DONE.
- CP_RD (1 cycle): mem_cs=1, mem_we=0, mem_addr=src. At the edge, buf<=mem_rdata; go to CP_WR.
- CP_WR (1 cycle): mem_cs=1, mem_we=1, mem_addr=dst, mem_wdata=buf.
  - At the edge: src++, dst++ (both mod 2^AW), cnt--.
  - If cnt was 1, go to DONE; else go to CP_RD.
  - A copy takes 2*len cycles.
- DONE (1 cycle): done=1, cmd_ready=0, busy=1. rd_valid=1 only if the op was read. Next state IDLE.
- Latency from the accept edge to the done pulse:
  - read/write: done high in the 2nd cycle after accept.
  - fill: len+1 cycles.
  - copy: 2*len+1 cycles.
  - len=0: 1 cycle.
- Back-to-back: the earliest next accept is the edge ending the IDLE cycle that follows DONE.
- Address wrap: pointers wrap 15->0. A fill of 16 starting at any address writes every location exactly once.
- Overlapping copy: strictly forward, word by word. If dst is inside (src, src+len), already-copied words are re-read (replication); this is defined behaviour, not an error.
- cmd_len > 2^AW saturates to 2^AW.
- mem_we is never 1 while mem_cs is 0.

Test Plan:
- Write then read: write addr 3, data 0xA5; then read addr 3 → mem_we high exactly 1 cycle with mem_addr=3; rd_valid pulse with rd_data=0xA5 two cycles after the read accept; done pulses once per command.
- Fill wrap: fill addr 14, len 4, data 0x3C → writes at 14,15,0,1 in consecutive cycles; done 5 cycles after accept; read of addr 2 returns its prior value.
- Copy: preload 0..3 with 0x10..0x13; copy src 0, dst 8, len 4 → addr 8..11 read back 0x10..0x13; done 9 cycles after accept; mem_cs never drops during the copy.
- Overlap and length edge cases:
  - Preload 0..3 = 1,2,3,4; copy src 0, dst 1, len 3 → addr 0..3 = 1,1,1,1.
  - len 0 → done 1 cycle after accept, no mem_cs activity.
  - len 31 behaves as 16.
- Reset mid-fill: fill addr 0, len 16, assert reset on the 5th FILL cycle → next cycle is IDLE with all outputs at reset values; exactly addr 0..4 modified; no done pulse.
- Handshake hold-off: hold cmd_valid high continuously with alternating write/read commands → each accepted exactly once; cmd_ready low from accept through DONE; no command lost or duplicated over 8 commands.
